matmul_sequencer: RTL and testbench

Hardware sequencer for the matrix-multiply accelerator. It sits on the dual-port memory-map bus (MMIO registers below 0x1000, SRAM at 0x1000 and above) in place of host-side stepping. When software sets MATMUL_Flag, it reads the operand bases and dimensions from MMIO, computes C = A·B with a single signed MAC, writes C back to SRAM, then clears the flag and pulses done.

---
 rtl/matmul_sequencer.sv | 239 +++++++++++++++++++++++
 tb/tb_matmul_sequencer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_sequencer.sv
// ---------------------------------------------------------------------------
// matmul_sequencer
//
// Replaces host-side stepping of the matrix-multiply accelerator. The block
// polls MATMUL_Flag over the dual-port memory-map bus. When it finds the flag
// set, it reads the operand bases and the dimensions from MMIO. It then
// computes C = A*B with one signed multiply-accumulate, writes every C word
// back to SRAM, clears the flag and pulses done.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   en                allows a new job to start (ignored while busy)
//   mem_addr_a/_data_a/_we_a/_q_a   port A: reads and the only writes
//   mem_addr_b/_data_b/_we_b/_q_b   port B: read-only (data/we tied low)
//   busy              high from CFG0 through DONE
//   done              one-cycle pulse at the end of a job
// ---------------------------------------------------------------------------
module matmul_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  output logic [ADDR_WIDTH-1:0] mem_addr_a,
  output logic [DATA_WIDTH-1:0] mem_data_a,
  output logic                  mem_we_a,
  input  logic [DATA_WIDTH-1:0] mem_q_a,
  output logic [ADDR_WIDTH-1:0] mem_addr_b,
  output logic [DATA_WIDTH-1:0] mem_data_b,
  output logic                  mem_we_b,
  input  logic [DATA_WIDTH-1:0] mem_q_b,
  output logic                  busy,
  output logic                  done
);

  localparam logic [ADDR_WIDTH-1:0] A_BASE_REG = ADDR_WIDTH'('h000);
  localparam logic [ADDR_WIDTH-1:0] B_BASE_REG = ADDR_WIDTH'('h100);
  localparam logic [ADDR_WIDTH-1:0] C_BASE_REG = ADDR_WIDTH'('h200);
  localparam logic [ADDR_WIDTH-1:0] M_REG      = ADDR_WIDTH'('h600);
  localparam logic [ADDR_WIDTH-1:0] N_REG      = ADDR_WIDTH'('h700);
  localparam logic [ADDR_WIDTH-1:0] P_REG      = ADDR_WIDTH'('h800);
  localparam logic [ADDR_WIDTH-1:0] FLAG_REG   = ADDR_WIDTH'('hA00);

  typedef enum logic [3:0] {
    POLL_ISSUE,
    POLL_CHECK,
    CFG0,
    CFG1,
    CFG2,
    CFG3,
    MAC,
    DRAIN,
    WRITE,
    CLEAR,
    DONE
  } state_t;

  state_t state, state_next;

  // Job configuration, captured once per job
  logic [ADDR_WIDTH-1:0] a_base, b_base, c_base;
  logic [DATA_WIDTH-1:0] m, n, p;

  // Loop counters and running address pointers
  logic [DATA_WIDTH-1:0] i, j, k;
  logic [ADDR_WIDTH-1:0] a_row;   // A_base + i*N
  logic [ADDR_WIDTH-1:0] b_col;   // B_base + j
  logic [ADDR_WIDTH-1:0] b_ptr;   // B_base + k*P + j
  logic [ADDR_WIDTH-1:0] c_ptr;   // C_base + i*P + j

  // MAC pipeline
  logic                  mac_valid, mac_first;
  logic [DATA_WIDTH-1:0] acc;
  logic signed [DATA_WIDTH-1:0] prod;

  logic k_last, j_last, last_elem, zero_dim;

  // Only the low DATA_WIDTH bits of the product are kept, so the
  // multiplication is sized to the accumulator and wraps naturally.
  assign prod = $signed(mem_q_a) * $signed(mem_q_b);

  assign k_last    = (k == n - DATA_WIDTH'(1));
  assign j_last    = (j == p - DATA_WIDTH'(1));
  assign last_elem = j_last && (i == m - DATA_WIDTH'(1));
  // N and P arrive on the bus during CFG3. They are not registered yet.
  assign zero_dim  = (m == '0) || (mem_q_a == '0) || (mem_q_b == '0);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= POLL_ISSUE;
    else     state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      POLL_ISSUE: if (en) state_next = POLL_CHECK;
      POLL_CHECK: state_next = (mem_q_a != '0) ? CFG0 : POLL_ISSUE;
      CFG0:       state_next = CFG1;
      CFG1:       state_next = CFG2;
      CFG2:       state_next = CFG3;
      CFG3:       state_next = zero_dim ? CLEAR : MAC;
      MAC:        if (k_last) state_next = DRAIN;
      DRAIN:      state_next = WRITE;
      WRITE:      state_next = last_elem ? CLEAR : MAC;
      CLEAR:      state_next = DONE;
      DONE:       state_next = POLL_ISSUE;
      default:    state_next = POLL_ISSUE;
    endcase
  end

  // Bus decode from registered state and counters only
  always_comb begin
    mem_addr_a = '0;
    mem_data_a = '0;
    mem_we_a   = 1'b0;
    mem_addr_b = '0;
    busy       = 1'b1;
    done       = 1'b0;
    case (state)
      POLL_ISSUE, POLL_CHECK: begin
        mem_addr_a = FLAG_REG;
        busy       = 1'b0;
      end
      CFG0: begin
        mem_addr_a = A_BASE_REG;
        mem_addr_b = B_BASE_REG;
      end
      CFG1: begin
        mem_addr_a = C_BASE_REG;
        mem_addr_b = M_REG;
      end
      CFG2: begin
        mem_addr_a = N_REG;
        mem_addr_b = P_REG;
      end
      MAC: begin
        mem_addr_a = a_row + k[ADDR_WIDTH-1:0];
        mem_addr_b = b_ptr;
      end
      WRITE: begin
        mem_addr_a = c_ptr;
        mem_data_a = acc;
        mem_we_a   = 1'b1;
      end
      CLEAR: begin
        mem_addr_a = FLAG_REG;
        mem_we_a   = 1'b1;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  assign mem_data_b = '0;
  assign mem_we_b   = 1'b0;

  // Configuration capture, loop counters and address pointers.
  // When a row of C wraps, the B pointer goes back to column 0 and the
  // A row pointer steps by N.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_base <= '0;
      b_base <= '0;
      c_base <= '0;
      m      <= '0;
      n      <= '0;
      p      <= '0;
      i      <= '0;
      j      <= '0;
      k      <= '0;
      a_row  <= '0;
      b_col  <= '0;
      b_ptr  <= '0;
      c_ptr  <= '0;
    end else begin
      case (state)
        CFG1: begin
          a_base <= mem_q_a[ADDR_WIDTH-1:0];
          b_base <= mem_q_b[ADDR_WIDTH-1:0];
        end
        CFG2: begin
          c_base <= mem_q_a[ADDR_WIDTH-1:0];
          m      <= mem_q_b;
        end
        CFG3: begin
          n     <= mem_q_a;
          p     <= mem_q_b;
          i     <= '0;
          j     <= '0;
          k     <= '0;
          a_row <= a_base;
          b_col <= b_base;
          b_ptr <= b_base;
          c_ptr <= c_base;
        end
        MAC: begin
          k     <= k + DATA_WIDTH'(1);
          b_ptr <= b_ptr + p[ADDR_WIDTH-1:0];
        end
        WRITE: begin
          k     <= '0;
          c_ptr <= c_ptr + ADDR_WIDTH'(1);
          if (j_last) begin
            j     <= '0;
            i     <= i + DATA_WIDTH'(1);
            a_row <= a_row + n[ADDR_WIDTH-1:0];
            b_col <= b_base;
            b_ptr <= b_base;
          end else begin
            j     <= j + DATA_WIDTH'(1);
            b_col <= b_col + ADDR_WIDTH'(1);
            b_ptr <= b_col + ADDR_WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Read data arrives one cycle after each MAC issue. mac_valid marks that
  // cycle. mac_first restarts the sum for a new C element, so nothing needs
  // to clear acc between elements.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mac_valid <= 1'b0;
      mac_first <= 1'b0;
      acc       <= '0;
    end else begin
      mac_valid <= (state == MAC);
      mac_first <= (state == MAC) && (k == '0);
      if (mac_valid)
        acc <= (mac_first ? '0 : acc) + DATA_WIDTH'(prod);
    end
  end

endmodule

// File: tb/tb_matmul_sequencer.sv
// ---------------------------------------------------------------------------
// tb_matmul_sequencer
//
// Self-checking bench for matmul_sequencer. It models the dual-port memory
// map with one word array. Jobs are loaded through a private bench write
// port. Results are compared with a plain nested-loop matrix product and
// with the job-length formula 4 + M*P*(N+2) + 2.
// ---------------------------------------------------------------------------
module tb_matmul_sequencer;

  logic        clk;
  logic        rst;
  logic        en;
  logic [15:0] mem_addr_a, mem_addr_b;
  logic [31:0] mem_data_a, mem_data_b;
  logic        mem_we_a, mem_we_b;
  logic [31:0] q_a, q_b;
  logic        busy, done;

  matmul_sequencer #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .mem_addr_a (mem_addr_a),
    .mem_data_a (mem_data_a),
    .mem_we_a   (mem_we_a),
    .mem_q_a    (q_a),
    .mem_addr_b (mem_addr_b),
    .mem_data_b (mem_data_b),
    .mem_we_b   (mem_we_b),
    .mem_q_b    (q_b),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model plus bench-side write port and write counters
  logic [31:0] mem [0:65535];
  logic        tb_we, tb_clr, cnt_clr;
  logic [15:0] tb_addr;
  logic [31:0] tb_data;
  int          sram_writes, flag_writes;

  always @(posedge clk) begin
    if (tb_clr) begin
      for (int x = 0; x < 65536; x++) mem[x] <= '0;
    end else begin
      if (tb_we) mem[tb_addr] <= tb_data;
      if (mem_we_a) mem[mem_addr_a] <= mem_data_a;
    end
    if (cnt_clr) begin
      sram_writes <= 0;
      flag_writes <= 0;
    end else if (mem_we_a) begin
      if (mem_addr_a >= 16'h1000) sram_writes <= sram_writes + 1;
      if (mem_addr_a == 16'hA00)  flag_writes <= flag_writes + 1;
    end
    q_a <= mem[mem_addr_a];
    q_b <= mem[mem_addr_b];
  end

  int checks = 0;
  int errors = 0;

  int aVal [0:15];
  int bVal [0:15];
  int expC [0:15];
  localparam logic [31:0] GARBAGE = 32'hDEADBEEF;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tbWrite(input logic [15:0] addr, input logic [31:0] data);
    tb_we   = 1'b1;
    tb_addr = addr;
    tb_data = data;
    @(negedge clk);
    tb_we   = 1'b0;
  endtask

  // Textbook matrix product with 32-bit wrapping int arithmetic
  task automatic computeModel(input int m, input int n, input int p);
    for (int r = 0; r < m; r++)
      for (int c = 0; c < p; c++) begin
        int s = 0;
        for (int t = 0; t < n; t++) s += aVal[r*n+t] * bVal[t*p+c];
        expC[r*p+c] = s;
      end
  endtask

  // Load the operands, prefill C with garbage, program MMIO, then set the flag
  task automatic applyStimulus(input int m, input int n, input int p,
                               input int aBase, input int bBase, input int cBase);
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    for (int x = 0; x < m*n; x++) tbWrite(16'(aBase + x), aVal[x]);
    for (int x = 0; x < n*p; x++) tbWrite(16'(bBase + x), bVal[x]);
    for (int x = 0; x < m*p; x++) tbWrite(16'(cBase + x), GARBAGE);
    tbWrite(16'h000, 32'(aBase));
    tbWrite(16'h100, 32'(bBase));
    tbWrite(16'h200, 32'(cBase));
    tbWrite(16'h600, 32'(m));
    tbWrite(16'h700, 32'(n));
    tbWrite(16'h800, 32'(p));
    tbWrite(16'hA00, 32'd1);
  endtask

  // Wait for busy, then count cycles from CFG0 through DONE inclusive
  task automatic monitorJob(input string tag, input int expLen, input int dropEnAt,
                            output int startWait);
    int cnt;
    logic busyOk;
    startWait = 0;
    while (!busy && startWait < 40) begin
      @(negedge clk);
      startWait++;
    end
    checkOutput({tag, "_start"}, 32'(busy), 32'd1);
    if (busy) begin
      cnt = 1;
      busyOk = 1'b1;
      while (!done && cnt < 1000) begin
        @(negedge clk);
        cnt++;
        if (!busy) busyOk = 1'b0;
        if (cnt == dropEnAt) en = 1'b0;
      end
      checkOutput({tag, "_len"}, 32'(cnt), 32'(expLen));
      checkOutput({tag, "_busy_thru"}, 32'(busyOk), 32'd1);
      @(negedge clk);
      checkOutput({tag, "_done_pulse"}, 32'(done), 32'd0);
      checkOutput({tag, "_idle_busy"}, 32'(busy), 32'd0);
    end
  endtask

  task automatic checkResult(input string tag, input int m, input int n, input int p,
                             input int cBase);
    logic zero;
    zero = (m == 0) || (n == 0) || (p == 0);
    computeModel(m, n, p);
    for (int x = 0; x < m*p; x++)
      checkOutput($sformatf("%s_c%0d", tag, x), mem[16'(cBase + x)],
                  zero ? GARBAGE : expC[x]);
    checkOutput({tag, "_flag"}, mem[16'hA00], 32'd0);
    checkOutput({tag, "_sram_writes"}, 32'(sram_writes), 32'(zero ? 0 : m*p));
    checkOutput({tag, "_flag_writes"}, 32'(flag_writes), 32'd1);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_addr_a"}, 32'(mem_addr_a), 32'h0A00);
    checkOutput({tag, "_addr_b"}, 32'(mem_addr_b), 32'h0);
    checkOutput({tag, "_data_a"}, mem_data_a, 32'h0);
    checkOutput({tag, "_data_b"}, mem_data_b, 32'h0);
    checkOutput({tag, "_we"}, 32'({mem_we_a, mem_we_b}), 32'h0);
    checkOutput({tag, "_busy_done"}, 32'({busy, done}), 32'h0);
  endtask

  initial begin
    int sw, m, n, p, pollCnt;
    logic anyWe, anyBusy;
    rst = 1'b1; en = 1'b0; tb_we = 1'b0; tb_addr = '0; tb_data = '0;
    tb_clr = 1'b1; cnt_clr = 1'b1;
    repeat (3) @(negedge clk);
    tb_clr = 1'b0; cnt_clr = 1'b0;
    checkResetOutputs("reset");
    rst = 1'b0;

    // Idle polling with the flag clear
    en = 1'b1;
    pollCnt = 0; anyWe = 1'b0; anyBusy = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (mem_addr_a == 16'hA00) pollCnt++;
      anyWe   = anyWe | mem_we_a;
      anyBusy = anyBusy | busy | done;
    end
    checkOutput("idle_poll_addr", 32'(pollCnt >= 10), 32'd1);
    checkOutput("idle_we", 32'(anyWe), 32'd0);
    checkOutput("idle_busy_done", 32'(anyBusy), 32'd0);

    // Directed 2x2x2 job
    aVal[0:3] = '{1, 2, 3, 4};
    bVal[0:3] = '{5, 6, 7, 8};
    applyStimulus(2, 2, 2, 'h1000, 'h1100, 'h1200);
    monitorJob("mm222", 22, 0, sw);
    checkResult("mm222", 2, 2, 2, 'h1200);
    checkOutput("mm222_c0_const", mem[16'h1200], 32'd19);
    checkOutput("mm222_c3_const", mem[16'h1203], 32'd50);

    // Signed products and 32-bit wrap on 1x1x1 jobs
    aVal[0] = -3; bVal[0] = 7;
    applyStimulus(1, 1, 1, 'h1300, 'h1310, 'h1320);
    monitorJob("neg", 9, 0, sw);
    checkResult("neg", 1, 1, 1, 'h1320);
    checkOutput("neg_const", mem[16'h1320], 32'hFFFFFFEB);
    aVal[0] = 32'h00010000; bVal[0] = 32'h00010000;
    applyStimulus(1, 1, 1, 'h1300, 'h1310, 'h1320);
    monitorJob("wrap", 9, 0, sw);
    checkResult("wrap", 1, 1, 1, 'h1320);

    // Zero inner dimension: no SRAM traffic, only the flag clear
    applyStimulus(2, 0, 2, 'h1400, 'h1410, 'h1420);
    monitorJob("zero", 6, 0, sw);
    checkResult("zero", 2, 0, 2, 'h1420);

    // Random jobs with random dimensions and full-range operands
    for (int r = 0; r < 4; r++) begin
      m = $urandom_range(1, 3); n = $urandom_range(1, 3); p = $urandom_range(1, 3);
      for (int x = 0; x < 9; x++) begin
        aVal[x] = $urandom;
        bVal[x] = $urandom;
      end
      applyStimulus(m, n, p, 'h2000, 'h2100, 'h2200);
      monitorJob($sformatf("rand%0d", r), 4 + m*p*(n+2) + 2, 0, sw);
      checkResult($sformatf("rand%0d", r), m, n, p, 'h2200);
    end

    // Reset during the second C element, then an automatic rerun
    aVal[0:3] = '{1, 2, 3, 4};
    bVal[0:3] = '{5, 6, 7, 8};
    applyStimulus(2, 2, 2, 'h1000, 'h1100, 'h1200);
    sw = 0;
    while (!busy && sw < 40) begin
      @(negedge clk);
      sw++;
    end
    checkOutput("rst_mid_start", 32'(busy), 32'd1);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    checkResetOutputs("rst_mid");
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    monitorJob("rerun", 22, 0, sw);
    checkResult("rerun", 2, 2, 2, 'h1200);

    // en gating: hold off while en is low, start promptly, ignore a mid-job drop
    en = 1'b0;
    @(negedge clk);
    applyStimulus(2, 2, 2, 'h1000, 'h1100, 'h1200);
    anyBusy = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      anyBusy = anyBusy | busy;
    end
    checkOutput("en_hold_busy", 32'(anyBusy), 32'd0);
    en = 1'b1;
    monitorJob("en_drop", 22, 8, sw);
    checkOutput("en_start_wait", 32'(sw <= 2), 32'd1);
    checkResult("en_drop", 2, 2, 2, 'h1200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
